count_monitor: RTL and testbench

- Receive-side checker for the 3-bit up/down counter (bit3) interface.
- Observes the same count/inc controls that drive the counter, together with the counter's q and cout outputs.
- Computes the expected sequence, flags mismatches, and counts wrap events.
- Sits beside the counter in benches and in system builds as a self-check and telemetry block.

---
 rtl/count_monitor_pkg.sv | 17 +
 rtl/count_monitor_if.sv | 30 +++
 rtl/count_monitor_sat_ctr.sv | 23 ++
 rtl/count_monitor.sv | 120 ++++++++++++
 tb/tb_count_monitor.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/count_monitor_pkg.sv
// Shared definitions for the up/down counter monitor: FSM states and the max-count helper.
// Imported by the monitor top and its interface users.
package count_monitor_pkg;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    SYNC  = 2'd1,
    TRACK = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 3;

  function automatic int unsigned max_of(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/count_monitor_if.sv
// Observation bundle between a counter's control/outputs and its monitor.
// Monitor only listens to count/inc/q/cout; clr and the result fields are its control/status.
interface count_monitor_if #(
  parameter int WIDTH  = 3,
  parameter int ERR_W  = 8,
  parameter int WRAP_W = 8
);
  logic              clr;
  logic              count;
  logic              inc;
  logic [WIDTH-1:0]  q;
  logic              cout;
  logic [WIDTH-1:0]  exp_q;
  logic              locked;
  logic              err;
  logic              sticky_err;
  logic [ERR_W-1:0]  err_cnt;
  logic [WRAP_W-1:0] wrap_up_cnt;
  logic [WRAP_W-1:0] wrap_dn_cnt;

  modport master (
    output clr, count, inc, q, cout,
    input  exp_q, locked, err, sticky_err, err_cnt, wrap_up_cnt, wrap_dn_cnt
  );

  modport slave (
    input  clr, count, inc, q, cout,
    output exp_q, locked, err, sticky_err, err_cnt, wrap_up_cnt, wrap_dn_cnt
  );
endinterface

// File: rtl/count_monitor_sat_ctr.sv
// Saturating event counter: holds at all-ones, synchronous clear has priority over inc.
// One-cycle update latency, no backpressure.
module sat_ctr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/count_monitor.sv
// Checks a WIDTH-bit up/down counter against its own controls and counts wrap events.
// Mismatches reported on err one edge after sampling; purely observing, no backpressure.
module count_monitor
  import count_monitor_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ERR_W  = 8,
  parameter int WRAP_W = 8
) (
  input  logic            clk,
  input  logic            set_n,
  count_monitor_if.slave  mon
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(max_of(WIDTH));

  function automatic logic [WIDTH-1:0] next_val(input logic [WIDTH-1:0] v,
                                                input logic c, input logic i);
    if (!c) return v;
    return i ? (v + WIDTH'(1)) : (v - WIDTH'(1));
  endfunction

  function automatic logic wraps(input logic [WIDTH-1:0] v,
                                 input logic c, input logic i);
    return c && ((i && (v == MAX)) || (!i && (v == '0)));
  endfunction

  state_t           state;
  logic [WIDTH-1:0] exp_q_r;
  logic [WIDTH-1:0] q_d;
  logic             count_d;
  logic             inc_d;
  logic             err_r;
  logic             sticky_r;
  logic             locked_r;

  logic tracking;
  logic exp_cout;
  logic mismatch;
  logic wrap_up;
  logic wrap_dn;

  assign tracking = (state == TRACK);
  // Predicted cout comes from last cycle's sample, matching the counter's registered flag.
  assign exp_cout = wraps(q_d, count_d, inc_d);
  assign mismatch = tracking && ((mon.q != exp_q_r) || (mon.cout != exp_cout));
  assign wrap_up  = tracking && mon.count && mon.inc && (mon.q == MAX);
  assign wrap_dn  = tracking && mon.count && !mon.inc && (mon.q == '0);

  always_ff @(posedge clk or negedge set_n) begin
    if (!set_n) begin
      state    <= WAIT;
      exp_q_r  <= '0;
      q_d      <= '0;
      count_d  <= 1'b0;
      inc_d    <= 1'b0;
      err_r    <= 1'b0;
      sticky_r <= 1'b0;
      locked_r <= 1'b0;
    end else begin
      q_d     <= mon.q;
      count_d <= mon.count;
      inc_d   <= mon.inc;
      err_r   <= mismatch;
      if (mon.clr) begin
        sticky_r <= 1'b0;
      end else if (mismatch) begin
        sticky_r <= 1'b1;
      end
      case (state)
        WAIT: begin
          state <= SYNC;
        end
        SYNC: begin
          exp_q_r  <= next_val(mon.q, mon.count, mon.inc);
          locked_r <= 1'b1;
          state    <= TRACK;
        end
        TRACK: begin
          // Always predict from the observed q so a single glitch costs one err only.
          exp_q_r <= next_val(mon.q, mon.count, mon.inc);
        end
        default: begin
          state    <= WAIT;
          locked_r <= 1'b0;
        end
      endcase
    end
  end

  assign mon.exp_q      = exp_q_r;
  assign mon.err        = err_r;
  assign mon.sticky_err = sticky_r;
  assign mon.locked     = locked_r;

  sat_ctr #(.W(ERR_W)) u_err_ctr (
    .clk   (clk),
    .rst_n (set_n),
    .clr   (mon.clr),
    .inc   (mismatch),
    .cnt   (mon.err_cnt)
  );

  sat_ctr #(.W(WRAP_W)) u_wrap_up_ctr (
    .clk   (clk),
    .rst_n (set_n),
    .clr   (mon.clr),
    .inc   (wrap_up),
    .cnt   (mon.wrap_up_cnt)
  );

  sat_ctr #(.W(WRAP_W)) u_wrap_dn_ctr (
    .clk   (clk),
    .rst_n (set_n),
    .clr   (mon.clr),
    .inc   (wrap_dn),
    .cnt   (mon.wrap_dn_cnt)
  );

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor: a behavioural 3-bit counter drives the monitor,
// with optional q glitch / cout drop overrides.
module tb_count_monitor;

  logic clk = 1'b0;
  logic set_n;
  always #5 clk = ~clk;

  count_monitor_if #(.WIDTH(3), .ERR_W(8), .WRAP_W(8)) mif ();

  count_monitor #(.WIDTH(3), .ERR_W(8), .WRAP_W(8)) dut (
    .clk   (clk),
    .set_n (set_n),
    .mon   (mif)
  );

  int errors = 0;
  int checks = 0;

  logic [2:0] cq;
  logic       ccout;
  logic       gl_en;
  logic [2:0] gl_q;
  logic       drop;

  // Drive one cycle of counter outputs/controls, advance the counter model, sample #1 after the edge.
  task automatic cyc(input logic c, input logic i);
    logic [2:0] qv;
    qv = gl_en ? gl_q : cq;
    mif.q     = qv;
    mif.cout  = drop ? 1'b0 : ccout;
    mif.count = c;
    mif.inc   = i;
    ccout = c && ((i && qv == 3'd7) || (!i && qv == 3'd0));
    cq    = c ? (i ? qv + 3'd1 : qv - 3'd1) : qv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_n = 1'b0;
    mif.clr = 1'b0; mif.count = 1'b0; mif.inc = 1'b0; mif.q = 3'd0; mif.cout = 1'b0;
    cq = 3'd0; ccout = 1'b0; gl_en = 1'b0; gl_q = 3'd0; drop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mif.exp_q !== 3'd0) begin errors++; $display("FAIL reset_exp_q: got %0d want 0", mif.exp_q); end
    checks++; if (mif.locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", mif.locked); end
    checks++; if (mif.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", mif.err); end
    checks++; if (mif.sticky_err !== 1'b0) begin errors++; $display("FAIL reset_sticky: got %b want 0", mif.sticky_err); end
    checks++; if (mif.err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d want 0", mif.err_cnt); end
    checks++; if (mif.wrap_up_cnt !== 8'd0) begin errors++; $display("FAIL reset_wrap_up: got %0d want 0", mif.wrap_up_cnt); end
    checks++; if (mif.wrap_dn_cnt !== 8'd0) begin errors++; $display("FAIL reset_wrap_dn: got %0d want 0", mif.wrap_dn_cnt); end
    set_n = 1'b1;
  endtask

  task automatic test_count_up();
    logic [2:0] want;
    for (int k = 1; k <= 10; k++) begin
      cyc(1'b1, 1'b1);
      want = (k >= 2) ? 3'(k % 8) : 3'd0;
      checks++; if (mif.locked !== (k >= 2)) begin errors++; $display("FAIL up_locked edge%0d: got %b want %b", k, mif.locked, (k >= 2)); end
      checks++; if (mif.exp_q !== want) begin errors++; $display("FAIL up_exp_q edge%0d: got %0d want %0d", k, mif.exp_q, want); end
      checks++; if (mif.err !== 1'b0) begin errors++; $display("FAIL up_err edge%0d: got %b want 0", k, mif.err); end
    end
    checks++; if (mif.wrap_up_cnt !== 8'd1) begin errors++; $display("FAIL up_wrap_cnt: got %0d want 1", mif.wrap_up_cnt); end
    checks++; if (mif.wrap_dn_cnt !== 8'd0) begin errors++; $display("FAIL up_wrap_dn: got %0d want 0", mif.wrap_dn_cnt); end
  endtask

  task automatic test_count_down();
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 1'b0);
      checks++; if (mif.err !== 1'b0) begin errors++; $display("FAIL dn_err step%0d: got %b want 0", k, mif.err); end
    end
    checks++; if (mif.wrap_dn_cnt !== 8'd1) begin errors++; $display("FAIL dn_wrap_cnt: got %0d want 1", mif.wrap_dn_cnt); end
    checks++; if (mif.err_cnt !== 8'd0) begin errors++; $display("FAIL dn_err_cnt: got %0d want 0", mif.err_cnt); end
    checks++; if (mif.exp_q !== 3'd5) begin errors++; $display("FAIL dn_exp_q: got %0d want 5", mif.exp_q); end
  endtask

  task automatic test_glitch();
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    gl_en = 1'b1; gl_q = 3'd5;
    cyc(1'b1, 1'b0);
    gl_en = 1'b0;
    checks++; if (mif.err !== 1'b1) begin errors++; $display("FAIL glitch_err: got %b want 1", mif.err); end
    checks++; if (mif.err_cnt !== 8'd1) begin errors++; $display("FAIL glitch_err_cnt: got %0d want 1", mif.err_cnt); end
    checks++; if (mif.sticky_err !== 1'b1) begin errors++; $display("FAIL glitch_sticky: got %b want 1", mif.sticky_err); end
    checks++; if (mif.exp_q !== 3'd4) begin errors++; $display("FAIL glitch_resync: got %0d want 4", mif.exp_q); end
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0);
      checks++; if (mif.err !== 1'b0) begin errors++; $display("FAIL glitch_after_err step%0d: got %b want 0", k, mif.err); end
    end
    checks++; if (mif.err_cnt !== 8'd1) begin errors++; $display("FAIL glitch_err_cnt_hold: got %0d want 1", mif.err_cnt); end
  endtask

  task automatic test_clr();
    mif.clr = 1'b1;
    cyc(1'b0, 1'b0);
    mif.clr = 1'b0;
    checks++; if (mif.err_cnt !== 8'd0) begin errors++; $display("FAIL clr_err_cnt: got %0d want 0", mif.err_cnt); end
    checks++; if (mif.sticky_err !== 1'b0) begin errors++; $display("FAIL clr_sticky: got %b want 0", mif.sticky_err); end
    checks++; if (mif.wrap_up_cnt !== 8'd0) begin errors++; $display("FAIL clr_wrap_up: got %0d want 0", mif.wrap_up_cnt); end
    checks++; if (mif.wrap_dn_cnt !== 8'd0) begin errors++; $display("FAIL clr_wrap_dn: got %0d want 0", mif.wrap_dn_cnt); end
    checks++; if (mif.exp_q !== 3'd1) begin errors++; $display("FAIL clr_exp_q: got %0d want 1", mif.exp_q); end
    checks++; if (mif.locked !== 1'b1) begin errors++; $display("FAIL clr_locked: got %b want 1", mif.locked); end
  endtask

  task automatic test_cout_drop();
    repeat (7) cyc(1'b1, 1'b1);
    drop = 1'b1;
    cyc(1'b1, 1'b1);
    drop = 1'b0;
    checks++; if (mif.err !== 1'b1) begin errors++; $display("FAIL drop_err: got %b want 1", mif.err); end
    checks++; if (mif.err_cnt !== 8'd1) begin errors++; $display("FAIL drop_err_cnt: got %0d want 1", mif.err_cnt); end
    checks++; if (mif.wrap_up_cnt !== 8'd1) begin errors++; $display("FAIL drop_wrap_up: got %0d want 1", mif.wrap_up_cnt); end
    cyc(1'b1, 1'b1);
    checks++; if (mif.err !== 1'b0) begin errors++; $display("FAIL drop_after_err: got %b want 0", mif.err); end
  endtask

  task automatic test_saturation();
    gl_en = 1'b1;
    for (int k = 0; k < 300; k++) begin
      gl_q = (k % 2 == 0) ? 3'd5 : 3'd2;
      cyc(1'b0, 1'b0);
    end
    checks++; if (mif.err_cnt !== 8'd255) begin errors++; $display("FAIL sat_err_cnt: got %0d want 255", mif.err_cnt); end
    checks++; if (mif.sticky_err !== 1'b1) begin errors++; $display("FAIL sat_sticky: got %b want 1", mif.sticky_err); end
    gl_q = 3'd5;
    mif.clr = 1'b1;
    cyc(1'b0, 1'b0);
    mif.clr = 1'b0;
    gl_en = 1'b0;
    checks++; if (mif.err_cnt !== 8'd0) begin errors++; $display("FAIL clr_vs_err_cnt: got %0d want 0", mif.err_cnt); end
    checks++; if (mif.sticky_err !== 1'b0) begin errors++; $display("FAIL clr_vs_sticky: got %b want 0", mif.sticky_err); end
    checks++; if (mif.err !== 1'b1) begin errors++; $display("FAIL clr_vs_err_pulse: got %b want 1", mif.err); end
    cyc(1'b0, 1'b0);
    checks++; if (mif.err !== 1'b0) begin errors++; $display("FAIL hold_err: got %b want 0", mif.err); end
    checks++; if (mif.err_cnt !== 8'd0) begin errors++; $display("FAIL hold_err_cnt: got %0d want 0", mif.err_cnt); end
  endtask

  task automatic test_async_reset();
    repeat (4) cyc(1'b1, 1'b1);
    checks++; if (mif.wrap_up_cnt !== 8'd1) begin errors++; $display("FAIL pre_rst_wrap_up: got %0d want 1", mif.wrap_up_cnt); end
    #2 set_n = 1'b0;
    #1;
    checks++; if (mif.exp_q !== 3'd0) begin errors++; $display("FAIL arst_exp_q: got %0d want 0", mif.exp_q); end
    checks++; if (mif.locked !== 1'b0) begin errors++; $display("FAIL arst_locked: got %b want 0", mif.locked); end
    checks++; if (mif.wrap_up_cnt !== 8'd0) begin errors++; $display("FAIL arst_wrap_up: got %0d want 0", mif.wrap_up_cnt); end
    #2 set_n = 1'b1;
    cyc(1'b1, 1'b1);
    checks++; if (mif.locked !== 1'b0) begin errors++; $display("FAIL rewait_locked: got %b want 0", mif.locked); end
    checks++; if (mif.exp_q !== 3'd0) begin errors++; $display("FAIL rewait_exp_q: got %0d want 0", mif.exp_q); end
    cyc(1'b1, 1'b1);
    checks++; if (mif.locked !== 1'b1) begin errors++; $display("FAIL resync_locked: got %b want 1", mif.locked); end
    checks++; if (mif.exp_q !== 3'd3) begin errors++; $display("FAIL resync_exp_q: got %0d want 3", mif.exp_q); end
    cyc(1'b1, 1'b1);
    checks++; if (mif.err !== 1'b0) begin errors++; $display("FAIL retrack_err: got %b want 0", mif.err); end
    checks++; if (mif.exp_q !== 3'd4) begin errors++; $display("FAIL retrack_exp_q: got %0d want 4", mif.exp_q); end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_glitch();
    test_clr();
    test_cout_drop();
    test_saturation();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
